mpq_feeder: RTL and testbench

- Upstream stage of the max-priority-queue engine. Buffers a host stream of data and command entries in an internal FIFO and replays them into the queue's load/command protocol: a contiguous data burst, then one command at a time gated by the engine's busy.
- Owns the engine's reset (mpq_rst), so every job starts with a clean load phase.
- Detects the end of a job from the engine's done.

---
 rtl/mpq_pkg.sv | 31 +++
 rtl/mpq_fifo.sv | 61 ++++++
 rtl/mpq_feeder.sv | 222 ++++++++++++++++++++++
 tb/tb_mpq_feeder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpq_pkg.sv
// mpq_pkg: shared definitions for the max-priority-queue feeder.
//   - engine command codes
//   - feeder FSM state encoding
//   - bit offsets of the fields inside a 20-bit FIFO entry
//     {type[19], cmd[18:16], index[15:8], value[7:0]}
package mpq_pkg;

  localparam logic [2:0] CMD_BUILD   = 3'd0;
  localparam logic [2:0] CMD_EXTRACT = 3'd1;
  localparam logic [2:0] CMD_SETKEY  = 3'd2;
  localparam logic [2:0] CMD_INSERT  = 3'd3;
  localparam logic [2:0] CMD_WRITE   = 3'd4;
  localparam logic [2:0] CMD_ADD8    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_CMD_IDLE = 3'd2,
    ST_GUARD    = 3'd3,
    ST_WAIT     = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_FINISH   = 3'd6
  } mpq_state_e;

  localparam int ENTRY_W   = 20;
  localparam int VALUE_LSB = 0;
  localparam int INDEX_LSB = 8;
  localparam int CMD_LSB   = 16;
  localparam int TYPE_BIT  = 19;

endpackage

// File: rtl/mpq_fifo.sv
// mpq_fifo: synchronous FIFO with a head peek.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (flushes pointers/count)
//   push, wdata     write request and entry; ignored when full
//   pop             read request; ignored when empty
//   head            entry at the read pointer, visible without popping
//   full, empty     occupancy flags
//   count           number of resident entries (0..DEPTH)
module mpq_fifo
  import mpq_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int W     = ENTRY_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mpq_feeder.sv
// mpq_feeder: buffers host data/command entries and replays them into the
// priority-queue engine as one contiguous key burst followed by commands
// issued one at a time, gated by the engine's busy.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   h_valid/h_ready          host entry handshake
//   h_type,h_cmd,h_index,h_value  host entry fields (type 0 = key, 1 = command)
//   busy, done               engine status (busy registered in the engine)
//   mpq_rst                  engine reset, held high between jobs
//   data_valid, data         key stream to the engine
//   cmd_valid,cmd,index,value  single-cycle command pulse to the engine
//   job_done                 one-cycle pulse per finished job
//   err                      sticky protocol error
//   state_dbg                current FSM state (mpq_state_e encoding)
//
// Host handshake: an entry transfers on every rising clk edge where
// h_valid && h_ready; h_ready is !full and does not depend on h_valid, and the
// host holds its entry stable while h_valid is high and h_ready is low.
// Engine side has no back-pressure: data_valid/cmd_valid are qualifiers only.
module mpq_feeder
  import mpq_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_valid,
  output logic       h_ready,
  input  logic       h_type,
  input  logic [2:0] h_cmd,
  input  logic [7:0] h_index,
  input  logic [7:0] h_value,
  input  logic       busy,
  input  logic       done,
  output logic       mpq_rst,
  output logic       data_valid,
  output logic [7:0] data,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [7:0] index,
  output logic [7:0] value,
  output logic       job_done,
  output logic       err,
  output logic [2:0] state_dbg
);

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic [AW:0]        cmd_cnt;
  logic               push;
  logic               pop;

  logic               head_type;
  logic [2:0]         head_cmd;
  logic [7:0]         head_index;
  logic [7:0]         head_value;
  logic               head_is_data;
  logic               head_is_cmd;

  mpq_state_e         state;
  mpq_state_e         state_n;
  logic               mpq_rst_n;
  logic               data_valid_n;
  logic [7:0]         data_n;
  logic               cmd_valid_n;
  logic [2:0]         cmd_n;
  logic [7:0]         index_n;
  logic [7:0]         value_n;
  logic               job_done_n;
  logic               err_set;

  assign h_ready = (fifo_count != (AW+1)'(DEPTH));
  assign push    = h_valid && h_ready;

  always_comb begin
    wr_entry                      = '0;
    wr_entry[TYPE_BIT]            = h_type;
    wr_entry[CMD_LSB +: 3]        = h_cmd;
    wr_entry[INDEX_LSB +: 8]      = h_index;
    wr_entry[VALUE_LSB +: 8]      = h_value;
  end

  mpq_fifo #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_type    = head[TYPE_BIT];
  assign head_cmd     = head[CMD_LSB +: 3];
  assign head_index   = head[INDEX_LSB +: 8];
  assign head_value   = head[VALUE_LSB +: 8];
  assign head_is_data = !fifo_empty && !head_type;
  assign head_is_cmd  = !fifo_empty && head_type;

  // A resident command means the key burst in front of it is complete, so the
  // load can stream without gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_cnt <= '0;
    end else begin
      unique case ({push && h_type, pop && head_is_cmd})
        2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
        2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic also computes the next value of every engine-side output,
  // so the outputs seen during a state are the ones chosen on entering it.
  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    err_set      = 1'b0;
    mpq_rst_n    = 1'b0;
    data_valid_n = 1'b0;
    data_n       = data;
    cmd_valid_n  = 1'b0;
    cmd_n        = cmd;
    index_n      = index;
    value_n      = value;
    job_done_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        mpq_rst_n = 1'b1;
        if (head_is_cmd) begin
          pop     = 1'b1;
          err_set = 1'b1;
        end else if (head_is_data && (cmd_cnt != '0 || fifo_full)) begin
          // Engine leaves reset on the same edge it captures the first key.
          pop          = 1'b1;
          data_n       = head_value;
          data_valid_n = 1'b1;
          mpq_rst_n    = 1'b0;
          state_n      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (head_is_data) begin
          pop          = 1'b1;
          data_n       = head_value;
          data_valid_n = 1'b1;
        end else begin
          state_n = ST_CMD_IDLE;
        end
      end
      ST_CMD_IDLE: begin
        if (head_is_data) begin
          pop     = 1'b1;
          err_set = 1'b1;
        end else if (head_is_cmd && !busy) begin
          pop         = 1'b1;
          cmd_valid_n = 1'b1;
          cmd_n       = head_cmd;
          index_n     = head_index;
          value_n     = head_value;
          state_n     = ST_GUARD;
        end
      end
      // Engine busy lags the command by one cycle, so it is not trusted here.
      ST_GUARD: state_n = (cmd == CMD_WRITE) ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (!busy) state_n = ST_CMD_IDLE;
      end
      ST_DRAIN: begin
        if (done) begin
          mpq_rst_n  = 1'b1;
          job_done_n = 1'b1;
          state_n    = ST_FINISH;
        end
      end
      ST_FINISH: begin
        mpq_rst_n = 1'b1;
        state_n   = ST_IDLE;
      end
      default: begin
        mpq_rst_n = 1'b1;
        state_n   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mpq_rst    <= 1'b1;
      data_valid <= 1'b0;
      data       <= '0;
      cmd_valid  <= 1'b0;
      cmd        <= '0;
      index      <= '0;
      value      <= '0;
      job_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      mpq_rst    <= mpq_rst_n;
      data_valid <= data_valid_n;
      data       <= data_n;
      cmd_valid  <= cmd_valid_n;
      cmd        <= cmd_n;
      index      <= index_n;
      value      <= value_n;
      job_done   <= job_done_n;
      err        <= err || err_set;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mpq_feeder.sv
// tb_mpq_feeder: directed bench for mpq_feeder. Drives and samples 1 ns after
// each rising edge; expected keys live in exp_q, command expectations in a
// vector table, multi-cycle corner cases in hand-written sequences.
module tb_mpq_feeder;
  import mpq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_valid;
  logic       h_ready;
  logic       h_type;
  logic [2:0] h_cmd;
  logic [7:0] h_index;
  logic [7:0] h_value;
  logic       busy;
  logic       done;
  logic       mpq_rst;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] index;
  logic [7:0] value;
  logic       job_done;
  logic       err;
  logic [2:0] state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [2:0] c;
    logic [7:0] i;
    logic [7:0] v;
    int         busy_cyc;
    logic [2:0] exp_cmd;
    logic [7:0] exp_index;
    logic [7:0] exp_value;
  } cmd_vec_t;

  cmd_vec_t vecs[6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  mpq_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .h_valid    (h_valid),
    .h_ready    (h_ready),
    .h_type     (h_type),
    .h_cmd      (h_cmd),
    .h_index    (h_index),
    .h_value    (h_value),
    .busy       (busy),
    .done       (done),
    .mpq_rst    (mpq_rst),
    .data_valid (data_valid),
    .data       (data),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .index      (index),
    .value      (value),
    .job_done   (job_done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_raw(input logic t, input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
    int guard;
    guard   = 0;
    h_valid = 1'b1;
    h_type  = t;
    h_cmd   = c;
    h_index = i;
    h_value = v;
    while (!h_ready && guard < 2000) begin
      step();
      guard++;
    end
    chk("push_ready", h_ready, 1);
    step();
    h_valid = 1'b0;
  endtask

  task automatic push_data(input logic [7:0] v);
    exp_q.push_back(v);
    push_raw(1'b0, 3'd0, 8'd0, v);
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
    push_raw(1'b1, c, i, v);
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int bound);
    for (int k = 0; k < bound && state_dbg !== st; k++) step();
    chk(name, state_dbg, st);
  endtask

  // Called at the sample where the first key of a burst is visible.
  task automatic check_load(input int n);
    logic [7:0] e;
    chk("load_mpq_rst", mpq_rst, 0);
    for (int k = 0; k < n; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk("load_dv", data_valid, 1);
      chk("load_data", data, e);
      step();
    end
    chk("load_end_dv", data_valid, 0);
    chk("load_end_state", state_dbg, ST_CMD_IDLE);
  endtask

  // From CMD_IDLE with an empty FIFO and busy low: write-out and done.
  task automatic finish_job();
    push_cmd(CMD_WRITE, 8'd0, 8'd0);
    wait_state("fj_guard", ST_GUARD, 4);
    chk("fj_cv", cmd_valid, 1);
    chk("fj_cmd", cmd, 4);
    step();
    chk("fj_drain", state_dbg, ST_DRAIN);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("fj_job_done", job_done, 1);
    chk("fj_mpq_rst", mpq_rst, 1);
    step();
    chk("fj_job_done_low", job_done, 0);
    chk("fj_idle", state_dbg, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{3'd3, 8'd5,   8'd20,  10, 3'd3, 8'd5,   8'd20};
    vecs[1] = '{3'd1, 8'd0,   8'd0,   0,  3'd1, 8'd0,   8'd0};
    vecs[2] = '{3'd2, 8'd200, 8'd255, 3,  3'd2, 8'd200, 8'd255};
    vecs[3] = '{3'd5, 8'd7,   8'd8,   1,  3'd5, 8'd7,   8'd8};
    vecs[4] = '{3'd6, 8'd1,   8'd2,   2,  3'd6, 8'd1,   8'd2};
    vecs[5] = '{3'd7, 8'd255, 8'd128, 0,  3'd7, 8'd255, 8'd128};

    rst = 1'b1; h_valid = 1'b0; h_type = 1'b0; h_cmd = '0; h_index = '0; h_value = '0;
    busy = 1'b0; done = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_mpq_rst", mpq_rst, 1);
    chk("rst_dv", data_valid, 0);
    chk("rst_data", data, 0);
    chk("rst_cv", cmd_valid, 0);
    chk("rst_cmd", {cmd, index, value}, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_err", err, 0);
    chk("rst_h_ready", h_ready, 1);
    chk("rst_state", state_dbg, ST_IDLE);

    // Job 1: keys 3,9,1,7 then build
    push_data(8'd3); push_data(8'd9); push_data(8'd1); push_data(8'd7);
    push_cmd(CMD_BUILD, 8'd0, 8'd0);
    chk("j1_held_in_reset", mpq_rst, 1);
    wait_state("j1_load", ST_LOAD, 5);
    check_load(4);
    step();
    chk("j1_build_cv", cmd_valid, 1);
    chk("j1_build_cmd", cmd, 0);
    chk("j1_guard", state_dbg, ST_GUARD);
    step();
    chk("j1_build_cv_low", cmd_valid, 0);
    chk("j1_wait", state_dbg, ST_WAIT);
    step();
    chk("j1_cmd_idle", state_dbg, ST_CMD_IDLE);

    // Command table: busy held high busy_cyc cycles before release
    for (int n = 0; n < 6; n++) begin
      busy = 1'b1;
      push_cmd(vecs[n].c, vecs[n].i, vecs[n].v);
      for (int k = 0; k < vecs[n].busy_cyc; k++) begin
        step();
        chk("vec_hold_cv", cmd_valid, 0);
      end
      busy = 1'b0;
      step();
      chk("vec_cv", cmd_valid, 1);
      chk("vec_cmd", cmd, vecs[n].exp_cmd);
      chk("vec_index", index, vecs[n].exp_index);
      chk("vec_value", value, vecs[n].exp_value);
      step();
      chk("vec_cv_pulse", cmd_valid, 0);
      chk("vec_wait", state_dbg, ST_WAIT);
      step();
      chk("vec_back", state_dbg, ST_CMD_IDLE);
    end

    // Write-out with the next job already queued; busy ignored in GUARD/DRAIN
    busy = 1'b1;
    push_cmd(CMD_WRITE, 8'd0, 8'd0);
    push_data(8'd11); push_data(8'd22);
    push_cmd(CMD_EXTRACT, 8'd0, 8'd0);
    busy = 1'b0;
    step();
    chk("wo_cv", cmd_valid, 1);
    chk("wo_cmd", cmd, 4);
    busy = 1'b1;
    step();
    chk("wo_drain", state_dbg, ST_DRAIN);
    chk("wo_cv_low", cmd_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wo_drain_hold", state_dbg, ST_DRAIN);
      chk("wo_drain_rst", mpq_rst, 0);
    end
    done = 1'b1;
    step();
    done = 1'b0; busy = 1'b0;
    chk("wo_job_done", job_done, 1);
    chk("wo_mpq_rst", mpq_rst, 1);
    chk("wo_finish", state_dbg, ST_FINISH);
    step();
    chk("wo_job_done_pulse", job_done, 0);
    chk("wo_idle_rst", mpq_rst, 1);
    step();
    chk("j2_load", state_dbg, ST_LOAD);
    check_load(2);
    step();
    chk("j2_cv", cmd_valid, 1);
    chk("j2_cmd", cmd, 1);
    step(); step();
    chk("j2_cmd_idle", state_dbg, ST_CMD_IDLE);
    finish_job();

    // Full FIFO, no command: load starts anyway and streams 512 keys
    for (int i = 0; i < 512; i++) begin
      chk("fill_h_ready", h_ready, 1);
      push_data(8'(i));
    end
    chk("full_h_ready", h_ready, 0);
    chk("full_idle", state_dbg, ST_IDLE);
    wait_state("full_load", ST_LOAD, 3);
    check_load(512);
    chk("full_exp_empty", exp_q.size(), 0);
    finish_job();

    // Protocol errors: command in IDLE, data in CMD_IDLE
    chk("err_before", err, 0);
    push_cmd(CMD_EXTRACT, 8'd1, 8'd1);
    step();
    chk("err_idle_cmd", err, 1);
    chk("err_idle_state", state_dbg, ST_IDLE);
    chk("err_idle_mpq_rst", mpq_rst, 1);
    push_data(8'd5);
    push_cmd(CMD_BUILD, 8'd0, 8'd0);
    wait_state("err_load", ST_LOAD, 4);
    check_load(1);
    step();
    chk("err_build_cmd", cmd, 0);
    chk("err_build_cv", cmd_valid, 1);
    step(); step();
    push_raw(1'b0, 3'd0, 8'd0, 8'd66);
    step();
    chk("err_data_drop_dv", data_valid, 0);
    chk("err_data_drop_state", state_dbg, ST_CMD_IDLE);
    chk("err_sticky", err, 1);
    finish_job();
    chk("err_still", err, 1);

    // Reset mid-load
    push_data(8'd1); push_data(8'd2); push_data(8'd3);
    push_cmd(CMD_BUILD, 8'd0, 8'd0);
    wait_state("ab_load", ST_LOAD, 4);
    chk("ab_first", data, 1);
    step();
    rst = 1'b1;
    step();
    chk("ab_mpq_rst", mpq_rst, 1);
    chk("ab_dv", data_valid, 0);
    chk("ab_data", data, 0);
    chk("ab_cv", cmd_valid, 0);
    chk("ab_err", err, 0);
    chk("ab_h_ready", h_ready, 1);
    chk("ab_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    exp_q.delete();
    step();
    push_data(8'd40);
    push_cmd(CMD_BUILD, 8'd0, 8'd0);
    wait_state("ab_reload", ST_LOAD, 4);
    check_load(1);
    chk("final_exp_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
